// File: rtl/mealy_stream_sched_if.sv
// Handshake and detector signals between the stream scheduler and its environment.
// The scheduler connects through the slave modport; the requester/detector side uses master.
interface mealy_stream_sched_if #(
    parameter int DATA_W = 8
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic              req0_valid;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              det_a;
    logic              det_k;
    logic              res_valid;
    logic              res_id;
    logic [CNT_W-1:0]  res_count;
    logic              busy;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, det_k,
        output req0_ready, req1_ready, det_a, res_valid, res_id, res_count, busy
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, det_k,
        input  req0_ready, req1_ready, det_a, res_valid, res_id, res_count, busy
    );
endinterface

// File: rtl/mealy_stream_sched.sv
// Round-robin scheduler that feeds words MSB-first into a shared bit-serial Mealy detector,
// counts hits per word, then flushes the detector with zero bits before reporting.
module mealy_stream_sched #(
    parameter int DATA_W   = 8,
    parameter int GAP_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mealy_stream_sched_if.slave  bus
);
    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam int PH_MAX = (DATA_W > GAP_BITS) ? DATA_W : GAP_BITS;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP,
        REPORT
    } state_e;

    state_e            state_q, state_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              det_a_q, det_a_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic              res_id_q, res_id_d;
    logic [CNT_W-1:0]  res_count_q, res_count_d;

    logic              take0, take1;
    logic              ready0, ready1;
    logic [DATA_W-1:0] word_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ph_q         <= '0;
            sh_q         <= '0;
            det_a_q      <= 1'b0;
            cnt_q        <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            res_id_q     <= 1'b0;
            res_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            ph_q         <= ph_d;
            sh_q         <= sh_d;
            det_a_q      <= det_a_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            res_id_q     <= res_id_d;
            res_count_q  <= res_count_d;
        end
    end

    // A tie goes to the requester that did not win last time.
    assign take0    = bus.req0_valid & (~bus.req1_valid | last_grant_q);
    assign take1    = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
    assign word_sel = take1 ? bus.req1_data : bus.req0_data;

    always_comb begin
        state_d      = state_q;
        ph_d         = ph_q;
        sh_d         = sh_q;
        det_a_d      = det_a_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        res_id_d     = res_id_q;
        res_count_d  = res_count_q;
        ready0       = 1'b0;
        ready1       = 1'b0;

        unique case (state_q)
            IDLE: begin
                det_a_d = 1'b0;
                if (take0 | take1) begin
                    ready0       = take0;
                    ready1       = take1;
                    grant_d      = take1;
                    last_grant_d = take1;
                    det_a_d      = word_sel[DATA_W-1];
                    sh_d         = word_sel << 1;
                    cnt_d        = '0;
                    ph_d         = '0;
                    state_d      = SHIFT;
                end
            end
            SHIFT: begin
                // The shifter fills with zeros, so the last SHIFT cycle loads det_a=0 for GAP.
                det_a_d = sh_q[DATA_W-1];
                sh_d    = sh_q << 1;
                if (bus.det_k) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (ph_q == PH_W'(DATA_W - 1)) begin
                    ph_d    = '0;
                    state_d = GAP;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            GAP: begin
                det_a_d = 1'b0;
                if (ph_q == PH_W'(GAP_BITS - 1)) begin
                    ph_d        = '0;
                    res_id_d    = grant_q;
                    res_count_d = cnt_q;
                    state_d     = REPORT;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            REPORT: begin
                det_a_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.det_a      = det_a_q;
    assign bus.res_valid  = (state_q == REPORT);
    assign bus.res_id     = res_id_q;
    assign bus.res_count  = res_count_q;
    assign bus.busy       = (state_q != IDLE);
endmodule
